// File: rtl/store_unit_aligned.sv
// Store engine: turns execute-stage stores into AXI-Lite AW/W beats with byte-lane alignment,
// traps misaligned and illegal widths, and reports in-order completion from the B channel.
module store_unit_aligned #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ALEN        = XLEN,
  parameter int unsigned DLEN        = XLEN,
  parameter int unsigned SLEN        = DLEN / 8,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_base_addr,
  input  logic [XLEN-1:0] i_offset,
  input  logic [2:0]      i_width,
  input  logic [XLEN-1:0] i_source,
  output logic            o_misaligned,
  output logic            o_illegal,
  output logic            o_done,
  output logic            o_err,
  output logic            o_busy,
  output logic            o_dm_awvalid,
  input  logic            i_dm_awready,
  output logic [ALEN-1:0] o_dm_awaddr,
  output logic [2:0]      o_dm_awprot,
  output logic            o_dm_wvalid,
  input  logic            i_dm_wready,
  output logic [DLEN-1:0] o_dm_wdata,
  output logic [SLEN-1:0] o_dm_wstrb,
  input  logic            i_dm_bvalid,
  output logic            o_dm_bready,
  input  logic [1:0]      i_dm_bresp
);

  localparam int unsigned LaneW  = $clog2(SLEN);
  localparam int unsigned CntW   = $clog2(OUTSTANDING + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(OUTSTANDING);
  localparam bit Rv32 = (XLEN == 32);

  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic [ALEN-1:0] awaddr_q, awaddr_d;
  logic [DLEN-1:0] wdata_q, wdata_d;
  logic [SLEN-1:0] wstrb_q, wstrb_d;
  logic [CntW-1:0] count_q, count_d;
  logic            misaligned_q, misaligned_d;
  logic            illegal_q, illegal_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [XLEN-1:0]  addr;
  logic [LaneW-1:0] lane;
  logic [XLEN-1:0]  byte_mask;
  logic [7:0]       strb_base;
  logic             is_illegal, is_misaligned;
  logic             accept, legal_acc, b_hs;

  assign addr = i_base_addr + i_offset;
  assign lane = addr[LaneW-1:0];

  // Width decode: data mask, base strobe and alignment check for the requested size.
  always_comb begin
    byte_mask     = '1;
    strb_base     = 8'hFF;
    is_misaligned = 1'b0;
    unique case (i_width[1:0])
      2'b00: begin
        byte_mask     = XLEN'(64'h0000_0000_0000_00FF);
        strb_base     = 8'h01;
        is_misaligned = 1'b0;
      end
      2'b01: begin
        byte_mask     = XLEN'(64'h0000_0000_0000_FFFF);
        strb_base     = 8'h03;
        is_misaligned = addr[0];
      end
      2'b10: begin
        byte_mask     = XLEN'(64'h0000_0000_FFFF_FFFF);
        strb_base     = 8'h0F;
        is_misaligned = |addr[1:0];
      end
      default: begin
        byte_mask     = '1;
        strb_base     = 8'hFF;
        is_misaligned = |addr[2:0];
      end
    endcase
    is_illegal = i_width[2] | (Rv32 & (i_width[1:0] == 2'b11));
  end

  // o_ready depends only on flops (plus reset), so there is no path from i_valid.
  assign o_ready     = ~awvalid_q & ~wvalid_q & (count_q < MaxCnt) & rstn;
  assign accept      = i_valid & o_ready;
  assign legal_acc   = accept & ~is_illegal & ~is_misaligned;
  assign o_dm_bready = (count_q != '0) & rstn;
  assign b_hs        = i_dm_bvalid & o_dm_bready;

  // Next state: independent AW/W valids, payload capture on accept, outstanding count, pulses.
  always_comb begin
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    count_d   = count_q;
    if (awvalid_q && i_dm_awready) awvalid_d = 1'b0;
    if (wvalid_q && i_dm_wready)   wvalid_d  = 1'b0;
    if (legal_acc) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awaddr_d  = ALEN'(addr);
      wdata_d   = DLEN'(i_source & byte_mask) << {lane, 3'b000};
      wstrb_d   = SLEN'(strb_base) << lane;
    end
    unique case ({legal_acc, b_hs})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    misaligned_d = accept & ~is_illegal & is_misaligned;
    illegal_d    = accept & is_illegal;
    done_d       = b_hs;
    err_d        = b_hs & i_dm_bresp[1];
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Valids are gated by rstn so asserting reset drops them without waiting for a clock edge.
  assign o_dm_awvalid = awvalid_q & rstn;
  assign o_dm_wvalid  = wvalid_q & rstn;
  assign o_dm_awaddr  = awaddr_q;
  assign o_dm_awprot  = 3'b000;
  assign o_dm_wdata   = wdata_q;
  assign o_dm_wstrb   = wstrb_q;
  assign o_misaligned = misaligned_q;
  assign o_illegal    = illegal_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_busy       = awvalid_q | wvalid_q | (count_q != '0);

endmodule
